// File: rtl/parking_time_keeper.sv
// ---------------------------------------------------------------------------
// parking_time_keeper
//
// Prescaled hour:minute:day time base for the parking manager. A 32-bit
// prescaler divides CLK down to one minute every TICK_DIV enabled cycles.
// Minutes roll into hours and hours roll into days. Time can be frozen (en=0)
// or preset at run time (load). A preset that is out of range is rejected
// and flagged with load_err.
//
// Ports:
//   CLK        in   system clock, rising edge
//   Start      in   asynchronous active-high reset, clears all state
//   en         in   1 = time advances, 0 = time and prescaler hold
//   load       in   1-cycle preset request (takes priority over counting)
//   load_hour  in   preset hour   [HOUR_W]
//   load_min   in   preset minute [MIN_W]
//   hour       out  current hour  [HOUR_W]
//   minute     out  current minute[MIN_W]
//   day        out  days since reset, modulo 2^DAY_W [DAY_W]
//   min_pulse  out  1-cycle strobe, minute advanced
//   hour_pulse out  1-cycle strobe, hour advanced
//   day_pulse  out  1-cycle strobe, hour wrapped to 0
//   load_err   out  1-cycle strobe, a load was rejected
//
// Strobe semantics: each *_pulse / load_err output is registered. It is
// high for exactly the cycle after the edge that caused it. There is no
// back-pressure, so consumers must sample every cycle. The pulses nest:
// day_pulse implies hour_pulse, and hour_pulse implies min_pulse.
// ---------------------------------------------------------------------------
module parking_time_keeper #(
   parameter int unsigned TICK_DIV      = 700,
   parameter int          MIN_PER_HOUR  = 60,
   parameter int          HOURS_PER_DAY = 24,
   parameter int          MIN_W         = 6,
   parameter int          HOUR_W        = 5,
   parameter int          DAY_W         = 8
) (
   input  logic              CLK,
   input  logic              Start,
   input  logic              en,
   input  logic              load,
   input  logic [HOUR_W-1:0] load_hour,
   input  logic [MIN_W-1:0]  load_min,
   output logic [HOUR_W-1:0] hour,
   output logic [MIN_W-1:0]  minute,
   output logic [DAY_W-1:0]  day,
   output logic              min_pulse,
   output logic              hour_pulse,
   output logic              day_pulse,
   output logic              load_err
);

   localparam logic [31:0]       PRE_TERM  = 32'(TICK_DIV - 1);
   localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MIN_PER_HOUR - 1);
   localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOURS_PER_DAY - 1);

   logic [31:0]       pre;
   logic [31:0]       pre_nxt;
   logic [HOUR_W-1:0] hour_nxt;
   logic [MIN_W-1:0]  minute_nxt;
   logic [DAY_W-1:0]  day_nxt;
   logic              min_pulse_nxt;
   logic              hour_pulse_nxt;
   logic              day_pulse_nxt;
   logic              load_err_nxt;

   logic load_ok;
   logic tick;

   assign load_ok = (load_hour <= HOUR_LAST) && (load_min <= MIN_LAST);
   // A terminal count only matters when no load competes for the edge.
   // A rejected load also blocks counting on its edge.
   assign tick    = en && !load && (pre == PRE_TERM);

   // Next-state logic. The default is hold with all strobes low.
   always_comb begin
      pre_nxt        = pre;
      hour_nxt       = hour;
      minute_nxt     = minute;
      day_nxt        = day;
      min_pulse_nxt  = 1'b0;
      hour_pulse_nxt = 1'b0;
      day_pulse_nxt  = 1'b0;
      load_err_nxt   = 1'b0;

      if (load) begin
         if (load_ok) begin
            hour_nxt   = load_hour;
            minute_nxt = load_min;
            pre_nxt    = 32'd0;
         end else begin
            load_err_nxt = 1'b1;
         end
      end else if (tick) begin
         pre_nxt       = 32'd0;
         min_pulse_nxt = 1'b1;
         if (minute == MIN_LAST) begin
            minute_nxt     = '0;
            hour_pulse_nxt = 1'b1;
            if (hour == HOUR_LAST) begin
               hour_nxt      = '0;
               day_nxt       = day + DAY_W'(1);
               day_pulse_nxt = 1'b1;
            end else begin
               hour_nxt = hour + HOUR_W'(1);
            end
         end else begin
            minute_nxt = minute + MIN_W'(1);
         end
      end else if (en) begin
         pre_nxt = pre + 32'd1;
      end
   end

   // State register. Start clears everything, including partial
   // prescaler progress.
   always_ff @(posedge CLK or posedge Start) begin
      if (Start) begin
         pre        <= 32'd0;
         hour       <= '0;
         minute     <= '0;
         day        <= '0;
         min_pulse  <= 1'b0;
         hour_pulse <= 1'b0;
         day_pulse  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         pre        <= pre_nxt;
         hour       <= hour_nxt;
         minute     <= minute_nxt;
         day        <= day_nxt;
         min_pulse  <= min_pulse_nxt;
         hour_pulse <= hour_pulse_nxt;
         day_pulse  <= day_pulse_nxt;
         load_err   <= load_err_nxt;
      end
   end

endmodule
